tbt_mult_client: RTL and testbench
==================================

Name: tbt_mult_client

Overview:
- Initiator for the 2x2 float matrix-multiply engine's load/result_ready/result_ack protocol.
- Accepts matrix-pair jobs on an upstream valid/ready port, holds one job in a buffer, and issues the job to the engine.
- Waits for the engine result, acknowledges it, and presents it on a downstream valid/ready port.
- Sits between the job source (system bus / test sequencer) and the engine instance.

Parameters:
- FLOATSIZE, 32, width of one IEEE-754 element; matrices are 4*FLOATSIZE bits packed {m11,m10,m01,m00}.
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream job valid.
- in_A  in  4*FLOATSIZE  left matrix.
- in_B  in  4*FLOATSIZE  right matrix.
- in_ready  out  1  input buffer empty.
- eng_load  out  1  engine load strobe.
- eng_A  out  4*FLOATSIZE  engine operand A.
- eng_B  out  4*FLOATSIZE  engine operand B.
- eng_result  in  4*FLOATSIZE  engine product.
- eng_result_ready  in  1  engine result valid, held until ack.
- eng_result_ack  out  1  engine result acknowledge.
- eng_reset_n  out  1  active-low engine reset.
- out_valid  out  1  product valid.
- out_data  out  4*FLOATSIZE  product.
- out_ready  in  1  downstream accept.
- busy  out  1  state != S_IDLE or buffer full.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: in_ready=1, eng_load=0, eng_result_ack=0, eng_reset_n=1, out_valid=0, out_data=0, eng_A=eng_B=0, busy=0, err=0, buffer empty, state S_IDLE.
- Input buffer (one entry):
  - Transfer when in_valid && in_ready; the pair is captured on that edge.
  - in_ready = !buf_full and is registered.
  - The buffer empties on the cycle the FSM moves S_IDLE->S_ISSUE and copies it into eng_A/eng_B.
  - A new job may be accepted while a previous job is in flight.
- FSM:
  - S_IDLE: if buf_full && !eng_result_ready, load eng_A/eng_B from the buffer, clear buf_full, go S_ISSUE.
  - S_ISSUE: eng_load=1 for exactly this cycle; go S_WAIT. eng_A/eng_B stay stable from S_ISSUE until the job leaves S_ACK.
  - S_WAIT: when eng_result_ready=1, capture out_data<=eng_result, set eng_result_ack=1, go S_ACK.
  - S_ACK: hold eng_result_ack=1 until eng_result_ready samples 0, then drop ack and go S_OUT. There is no cycle limit.
  - S_OUT: out_valid=1 with stable out_data. On out_ready, out_valid<=0. Next state is S_ISSUE (buffer loaded as in S_IDLE) if buf_full and eng_result_ready=0, else S_IDLE.
- Latency: from the in_valid handshake to eng_load high is 2 cycles when idle. out_valid rises 1 cycle after eng_result_ready falls.
- Simultaneous events:
  - A buffer fill and drain in the same cycle is illegal by construction, because in_ready is registered low while full.
  - out_ready asserted the same cycle out_valid rises is accepted on that edge.
- Asynchronous reset mid-job: the job and buffer are discarded and all outputs return to reset values. The engine is reset through eng_reset_n only in the timeout path; the top level also ties engine reset to ~reset.

Optional Feature:
- Macro TBT_CLIENT_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on S_ISSUE and increments in S_WAIT and S_ACK.
  - On reaching TIMEOUT_CYCLES: pulse eng_reset_n=0 for 2 cycles, drop eng_result_ack, set err=1 (cleared only by reset), discard the job without out_valid, and go to S_IDLE.
- Undefined: no counter; eng_reset_n constant 1; err constant 0.

Decomposition:
- Package tbt_pkg holds:
  - State encoding S_IDLE..S_OUT (3 bits).
  - The matrix-packing localparam MAT_W = 4*FLOATSIZE.
  - The default TIMEOUT_CYCLES.
- One natural sub-module: tbt_job_buffer, a single-entry register with valid, load and clear.

Test Plan:
- Single job, behavioural engine with 5-cycle latency. A=identity {3F800000,0,0,3F800000}, B={40800000,40400000,40000000,3F800000} -> one-cycle eng_load; out_data=B; eng_result_ack held until eng_result_ready low.
- Back-to-back jobs, second presented during S_WAIT -> second accepted immediately, in_ready low while buffered, second eng_load only after first out handshake; 2 outputs in order.
- Downstream stall: out_ready=0 for 10 cycles -> out_valid and out_data stable, no new eng_load.
- Engine holds eng_result_ready for 3 cycles after ack -> client stays in S_ACK, no duplicate capture, single output.
- Async reset asserted in S_WAIT -> all outputs at reset values the same cycle, no output after release.
- With TBT_CLIENT_TIMEOUT_EN and TIMEOUT_CYCLES=20, engine never responds -> at cycle 20 eng_reset_n low for 2 cycles, err=1, no out_valid, next job processed normally.

Source files
------------

// File: rtl/tbt_pkg.sv
// -----------------------------------------------------------------------------
// tbt_pkg
// Shared definitions for the 2x2 float matrix-multiply engine client.
//   - state_e            : client FSM encoding (S_IDLE..S_OUT, 3 bits)
//   - FLOATSIZE_DEF      : default IEEE-754 element width
//   - MAT_W              : packed matrix width {m11,m10,m01,m00} at the default size
//   - TIMEOUT_CYCLES_DEF : default watchdog limit in clk cycles
//   - TMO_W              : watchdog counter width
//   - mat_width()        : packed matrix width for a given element width
// -----------------------------------------------------------------------------
package tbt_pkg;

  localparam int FLOATSIZE_DEF      = 32;
  localparam int MAT_W              = 4 * FLOATSIZE_DEF;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TMO_W              = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  function automatic int mat_width(input int floatsize);
    return 4 * floatsize;
  endfunction

endpackage

// File: rtl/tbt_job_buffer.sv
// -----------------------------------------------------------------------------
// tbt_job_buffer
// Single-entry holding register for one matrix-pair job.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the entry)
//   load_i      : capture data_i and mark the entry full
//   clear_i     : mark the entry empty (payload is left as is)
//   data_i      : job payload in
//   data_o      : stored job payload
//   full_o      : entry holds a job
// -----------------------------------------------------------------------------
module tbt_job_buffer #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // NOTE: registered state is always written with <= so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only observed while full_q is set,
  // so resetting it would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/tbt_mult_client.sv
// -----------------------------------------------------------------------------
// tbt_mult_client
// Initiator for the 2x2 float matrix-multiply engine (load / result_ready /
// result_ack). Accepts jobs upstream, buffers one, issues it to the engine,
// acknowledges the result and presents it downstream.
// Optional watchdog: define TBT_CLIENT_TIMEOUT_EN to enable the timeout path
// (engine reset pulse, sticky err, job discard). Undefined: eng_reset_n = 1,
// err = 0.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid/in_A/in_B/in_ready: upstream job port (in_ready = buffer empty)
//   eng_load/eng_A/eng_B       : engine issue strobe and operands
//   eng_result/eng_result_ready: engine product, valid until acknowledged
//   eng_result_ack             : engine result acknowledge
//   eng_reset_n                : active-low engine reset (watchdog only)
//   out_valid/out_data/out_ready: downstream product port
//   busy                       : FSM not idle or buffer full
//   err                        : sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module tbt_mult_client
  import tbt_pkg::*;
#(
  parameter int FLOATSIZE      = FLOATSIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [4*FLOATSIZE-1:0] in_A,
  input  logic [4*FLOATSIZE-1:0] in_B,
  output logic                   in_ready,
  output logic                   eng_load,
  output logic [4*FLOATSIZE-1:0] eng_A,
  output logic [4*FLOATSIZE-1:0] eng_B,
  input  logic [4*FLOATSIZE-1:0] eng_result,
  input  logic                   eng_result_ready,
  output logic                   eng_result_ack,
  output logic                   eng_reset_n,
  output logic                   out_valid,
  output logic [4*FLOATSIZE-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int MW = mat_width(FLOATSIZE);

  state_e          state_q, state_d;
  logic            buf_full;
  logic [2*MW-1:0] buf_data;
  logic            take_job;     // FSM moves the buffered job into eng_A/eng_B
  logic            timeout_hit;  // watchdog expired this cycle
  logic            eng_up;       // engine is out of its watchdog reset
  logic [MW-1:0]   eng_a_q, eng_b_q, out_data_q;

  // ---------------------------------------------------------------------------
  // Input buffer: in_ready comes straight from the full flag, so a fill and a
  // drain can never coincide.
  // ---------------------------------------------------------------------------
  assign in_ready = !buf_full;

  tbt_job_buffer #(.W(2*MW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (in_valid && !buf_full),
    .clear_i (take_job),
    .data_i  ({in_A, in_B}),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A job is only issued while the engine shows no stale
  // result, so a leftover result_ready cannot be mistaken for the new product.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d  = state_q;
    take_job = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (buf_full && !eng_result_ready && eng_up) begin
          state_d  = S_ISSUE;
          take_job = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_result_ready) state_d = S_ACK;
      end
      S_ACK: begin
        if (!eng_result_ready) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (buf_full && !eng_result_ready) begin
            state_d  = S_ISSUE;
            take_job = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all decoded from the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    eng_load       = (state_q == S_ISSUE);
    eng_result_ack = (state_q == S_ACK);
    out_valid      = (state_q == S_OUT);
    busy           = (state_q != S_IDLE) || buf_full;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operands stay put from issue until the next job is taken;
  // the product is captured once, on the S_WAIT -> S_ACK edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_a_q    <= '0;
      eng_b_q    <= '0;
      out_data_q <= '0;
    end else begin
      if (take_job) begin
        {eng_a_q, eng_b_q} <= buf_data;
      end
      if (state_q == S_WAIT && eng_result_ready) begin
        out_data_q <= eng_result;
      end
    end
  end

  assign eng_A    = eng_a_q;
  assign eng_B    = eng_b_q;
  assign out_data = out_data_q;

`ifdef TBT_CLIENT_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: counts cycles spent waiting on the engine. On expiry the engine
  // is held in reset for two cycles and the job is dropped.
  // ---------------------------------------------------------------------------
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       rst_cnt_q, rst_cnt_d;
  logic             err_q, err_d;
  logic             waiting;

  assign waiting     = (state_q == S_WAIT) || (state_q == S_ACK);
  assign timeout_hit = waiting && (tmo_cnt_q == TMO_LAST);
  assign eng_up      = (rst_cnt_q == 2'd0);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    rst_cnt_d = rst_cnt_q;
    err_d     = err_q;
    if (state_q == S_ISSUE) begin
      tmo_cnt_d = '0;
    end else if (waiting) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (rst_cnt_q != 2'd0) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end
    if (timeout_hit) begin
      rst_cnt_d = 2'd2;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      rst_cnt_q <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      err_q     <= err_d;
    end
  end

  assign eng_reset_n = eng_up;
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign eng_up      = 1'b1;
  assign eng_reset_n = 1'b1;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_tbt_mult_client.sv
// -----------------------------------------------------------------------------
// tb_tbt_mult_client
// Scoreboard bench: the stimulus pushes each job's hand-computed product into
// exp_q; a monitor pops and compares on every downstream handshake. A
// behavioural engine returns products from the directed vector table, looked
// up by the operands it actually receives.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tbt_mult_client;

  localparam int MW = 128;
  localparam int NV = 4;
`ifdef TBT_CLIENT_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 1024;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [MW-1:0] in_A, in_B;
  logic          in_ready;
  logic          eng_load;
  logic [MW-1:0] eng_A, eng_B;
  logic [MW-1:0] eng_result;
  logic          eng_result_ready;
  logic          eng_result_ack;
  logic          eng_reset_n;
  logic          out_valid;
  logic [MW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          err;

  tbt_mult_client #(.FLOATSIZE(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_A             (in_A),
    .in_B             (in_B),
    .in_ready         (in_ready),
    .eng_load         (eng_load),
    .eng_A            (eng_A),
    .eng_B            (eng_B),
    .eng_result       (eng_result),
    .eng_result_ready (eng_result_ready),
    .eng_result_ack   (eng_result_ack),
    .eng_reset_n      (eng_reset_n),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Directed vectors, packed {m11,m10,m01,m00}; vc = va x vb by hand.
  logic [MW-1:0] va [NV] = '{
    {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000},  // I
    {32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000},  // 2I
    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},  // all ones
    {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000}   // I
  };
  logic [MW-1:0] vb [NV] = '{
    {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},  // [1 2;3 4]
    {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
    {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
    {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000}   // I
  };
  logic [MW-1:0] vc [NV] = '{
    {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},  // [1 2;3 4]
    {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000},  // [2 4;6 8]
    {32'h40C00000, 32'h40800000, 32'h40C00000, 32'h40800000},  // [4 6;4 6]
    {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000}   // I
  };

  logic [MW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int loads_seen = 0;
  int outs_done  = 0;

  // Engine model knobs
  int lat = 5;
  int hold_extra_cfg = 0;
  bit never_respond = 1'b0;

  task automatic check(input string name, input logic [MW-1:0] act,
                       input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] lookup(input logic [MW-1:0] a,
                                           input logic [MW-1:0] b);
    for (int i = 0; i < NV; i++) begin
      if (va[i] == a && vb[i] == b) return vc[i];
    end
    return {4{32'h7FC00000}};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural engine: samples and drives mid-cycle (negedge).
  // ---------------------------------------------------------------------------
  initial begin : engine
    int cnt;
    int hold;
    logic [MW-1:0] res;
    bit prev_load, prev_ack, prev_rr;
    cnt = 0; hold = 0; res = '0;
    prev_load = 1'b0; prev_ack = 1'b0; prev_rr = 1'b0;
    eng_result_ready = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (reset || !eng_reset_n) begin
        eng_result_ready = 1'b0;
        cnt = 0;
        prev_load = 1'b0; prev_ack = 1'b0; prev_rr = 1'b0;
        loads_seen = outs_done;
        continue;
      end
      if (prev_ack && !eng_result_ack) begin
        check("ack_dropped_with_rr_low", prev_rr, 0);
        check("out_valid_after_rr_fall", out_valid, 1);
      end
      if (eng_load) begin
        check("load_single_cycle", prev_load, 0);
        check("load_no_overlap", loads_seen, outs_done);
        loads_seen++;
        res = lookup(eng_A, eng_B);
        if (!never_respond) cnt = lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_result_ready = 1'b1;
          eng_result = res;
          hold = hold_extra_cfg;
        end
      end else if (eng_result_ready && eng_result_ack) begin
        if (hold > 0) hold--;
        else eng_result_ready = 1'b0;
      end
      prev_load = eng_load;
      prev_ack  = eng_result_ack;
      prev_rr   = eng_result_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares each downstream handshake with the scoreboard and checks
  // that a stalled output holds.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit pv;
    logic [MW-1:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (pv) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
        else check("out_data", out_data, exp_q.pop_front());
        outs_done++;
        pv = 1'b0;
      end else begin
        pv = out_valid;
      end
      pd = out_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_job(input int idx, input bit expect_out);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_A = va[idx];
    in_B = vb[idx];
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    if (expect_out) exp_q.push_back(vc[idx]);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, (exp_q.size() != 0 || busy), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"},
          {in_ready, eng_load, eng_result_ack, eng_reset_n, out_valid, busy, err},
          7'b1001000);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_eng_A"}, eng_A, 0);
    check({tag, "_eng_B"}, eng_B, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int o0, l0, t, lows;
    reset = 1'b1;
    in_valid = 1'b0;
    in_A = '0;
    in_B = '0;
    out_ready = 1'b1;
    #12;
    check_reset("por");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single job, identity x B: operands issue two edges after the handshake.
    send_job(0, 1'b1);
    check("in_ready_low_when_full", in_ready, 0);
    @(posedge clk); #1;
    check("load_latency", eng_load, 1);
    check("eng_A_issued", eng_A, va[0]);
    check("eng_B_issued", eng_B, vb[0]);
    wait_idle("single_job_done", 100);

    // Back-to-back: second job arrives while the first is in S_WAIT.
    o0 = outs_done;
    send_job(1, 1'b1);
    repeat (3) @(posedge clk);
    send_job(2, 1'b1);
    check("second_buffered_in_ready", in_ready, 0);
    check("second_buffered_busy", busy, 1);
    wait_idle("back_to_back_done", 200);
    check("back_to_back_count", outs_done - o0, 2);

    // Downstream stall with a second job waiting in the buffer.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_job(3, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    send_job(0, 1'b1);
    l0 = loads_seen;
    repeat (10) @(posedge clk);
    #1;
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, vc[3]);
    check("stall_no_load", loads_seen, l0);
    out_ready = 1'b1;
    wait_idle("stall_done", 200);

    // Engine keeps result_ready up 3 cycles after the ack.
    hold_extra_cfg = 3;
    o0 = outs_done;
    send_job(2, 1'b1);
    wait_idle("hold_done", 200);
    check("hold_single_output", outs_done - o0, 1);
    hold_extra_cfg = 0;

    // Asynchronous reset while the job sits in S_WAIT.
    lat = 20;
    send_job(1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset("mid_job");
    @(posedge clk); #1;
    reset = 1'b0;
    o0 = outs_done;
    repeat (30) @(posedge clk);
    #1;
    check("no_output_after_reset", outs_done, o0);
    check("idle_after_reset", busy, 0);
    lat = 5;

`ifdef TBT_CLIENT_TIMEOUT_EN
    // Engine never answers: watchdog fires TMO cycles into S_WAIT.
    never_respond = 1'b1;
    send_job(0, 1'b0);
    @(posedge clk); #1;
    check("tmo_load", eng_load, 1);
    t = 0;
    while (eng_reset_n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("tmo_cycles", t, TMO + 1);
    check("tmo_err", err, 1);
    check("tmo_no_ack", eng_result_ack, 0);
    lows = 0;
    while (!eng_reset_n && lows < 10) begin
      @(posedge clk); #1;
      lows++;
    end
    check("tmo_reset_pulse_len", lows, 2);
    never_respond = 1'b0;
    send_job(3, 1'b1);
    wait_idle("tmo_next_job_done", 200);
    check("tmo_err_sticky", err, 1);
`else
    check("no_watchdog_err", err, 0);
    check("no_watchdog_eng_reset", eng_reset_n, 1);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
